// File: rtl/monitor_pkg.sv
// Shared types and helpers for the automata stage report path: the event
// layout {vec, offset} and a lowest-set-bit priority encoder.
package monitor_pkg;

  localparam int DEF_NUM_REPORTS = 20;
  localparam int DEF_OFFSET_W    = 32;
  localparam int NUM_REPORTS     = DEF_NUM_REPORTS;
  localparam int ID_W            = $clog2(NUM_REPORTS);
  localparam int ENC_W           = 64;

  typedef struct packed {
    logic [NUM_REPORTS-1:0]  vec;
    logic [DEF_OFFSET_W-1:0] offset;
  } report_event_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int lowest_set_idx(input logic [ENC_W-1:0] vec);
    int idx;
    idx = 0;
    for (int i = ENC_W - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
      else        idx = idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/report_event_fifo.sv
// Synchronous event FIFO with an extra pointer bit for full detection; a pop
// in the same cycle frees room for a push into a full FIFO.
module report_event_fifo #(
  parameter int DW    = 52,
  parameter int DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o   = (wr_q == rd_q);
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign rd_data_o = mem_q[rd_q[AW-1:0]];

  // Storage and pointer update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_q[AW-1:0]] <= push_data_i;
        wr_q                <= wr_q + PW'(1);
      end
      if (pop_ok_s) begin
        rd_q <= rd_q + PW'(1);
      end
    end
  end

endmodule

// File: rtl/automata_stage_report_pipe.sv
// Registers the symbol stream for the next automata stage and serialises the
// automata report vectors into a tagged (id, offset) event stream.
module automata_stage_report_pipe
  import monitor_pkg::*;
#(
  parameter int SYMBOL_W    = 8,
  parameter int NUM_REPORTS = DEF_NUM_REPORTS,
  parameter int REPORT_LAT  = 1,
  parameter int FIFO_DEPTH  = 8,
  parameter int OFFSET_W    = DEF_OFFSET_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           run,
  input  logic [SYMBOL_W-1:0]            in_symbols,
  input  logic                           in_reset,
  input  logic                           report_valid,
  input  logic [NUM_REPORTS-1:0]         report_in,
  output logic [SYMBOL_W-1:0]            out_symbols,
  output logic                           out_reset,
  output logic                           out_run,
  output logic                           rpt_valid,
  input  logic                           rpt_ready,
  output logic [$clog2(NUM_REPORTS)-1:0] rpt_id,
  output logic [OFFSET_W-1:0]            rpt_offset,
  output logic                           overflow,
  input  logic                           clr_overflow,
  output logic [15:0]                    drop_cnt
);

  localparam int RID_W = $clog2(NUM_REPORTS);
  localparam int EV_W  = NUM_REPORTS + OFFSET_W;

  logic [SYMBOL_W-1:0]    out_symbols_q;
  logic                   out_reset_q;
  logic                   out_run_q;
  logic [OFFSET_W-1:0]    off_q;
  logic [OFFSET_W-1:0]    off_d;
  logic [OFFSET_W-1:0]    tag_q [REPORT_LAT];
  logic [NUM_REPORTS-1:0] done_mask_q;
  logic [NUM_REPORTS-1:0] done_mask_d;
  logic                   overflow_q;
  logic                   overflow_d;
  logic [15:0]            drop_cnt_q;
  logic [15:0]            drop_cnt_d;

  logic                   push_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   fire_s;
  logic                   last_s;
  logic                   pop_s;
  logic                   drop_s;
  logic [EV_W-1:0]        head_s;
  logic [NUM_REPORTS-1:0] head_vec_s;
  logic [OFFSET_W-1:0]    head_off_s;
  logic [NUM_REPORTS-1:0] pend_s;
  logic [NUM_REPORTS-1:0] sel_s;
  logic [ENC_W-1:0]       enc_in_s;
  logic [RID_W-1:0]       id_s;

  // A restarting symbol keeps the old count; the symbol after it is offset 0.
  always_comb begin
    off_d = off_q;
    if (run) begin
      if (in_reset) off_d = '0;
      else          off_d = off_q + OFFSET_W'(1);
    end else begin
      off_d = off_q;
    end
  end

  // Symbol pipe, offset counter and report-latency offset delay line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_symbols_q <= '0;
      out_reset_q   <= 1'b0;
      out_run_q     <= 1'b0;
      off_q         <= '0;
      for (int i = 0; i < REPORT_LAT; i++) tag_q[i] <= '0;
    end else begin
      out_run_q <= run;
      off_q     <= off_d;
      if (run) begin
        out_symbols_q <= in_symbols;
        out_reset_q   <= in_reset;
        tag_q[0]      <= off_q;
        for (int i = 1; i < REPORT_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign push_s = report_valid && (report_in != '0);

  report_event_fifo #(
    .DW   (EV_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .push_i     (push_s),
    .push_data_i({report_in, tag_q[REPORT_LAT-1]}),
    .pop_i      (pop_s),
    .rd_data_o  (head_s),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s)
  );

  assign {head_vec_s, head_off_s} = head_s;
  assign pend_s = head_vec_s & ~done_mask_q;

  // Zero-extend the pending bits to the shared encoder width.
  always_comb begin
    enc_in_s                  = '0;
    enc_in_s[NUM_REPORTS-1:0] = pend_s;
  end

  assign id_s   = RID_W'(lowest_set_idx(enc_in_s));
  assign sel_s  = NUM_REPORTS'(1) << id_s;
  assign fire_s = !fifo_empty_s && rpt_ready;
  assign last_s = ((pend_s & ~sel_s) == '0);
  assign pop_s  = fire_s && last_s;
  assign drop_s = push_s && fifo_full_s && !pop_s;

  // Completed bits of the head batch; cleared as the batch leaves.
  always_comb begin
    done_mask_d = done_mask_q;
    if (pop_s)       done_mask_d = '0;
    else if (fire_s) done_mask_d = done_mask_q | sel_s;
    else             done_mask_d = done_mask_q;
  end

  // A drop outranks a same-cycle clear so that the drop is never lost.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_s) begin
      overflow_d = 1'b1;
      if (clr_overflow)                drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      else                             drop_cnt_d = drop_cnt_q;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Serializer and overflow state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_mask_q <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 16'd0;
    end else begin
      done_mask_q <= done_mask_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_symbols = out_symbols_q;
  assign out_reset   = out_reset_q;
  assign out_run     = out_run_q;
  assign rpt_valid   = !fifo_empty_s;
  assign rpt_id      = rpt_valid ? id_s : '0;
  assign rpt_offset  = rpt_valid ? head_off_s : '0;
  assign overflow    = overflow_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_automata_stage_report_pipe.sv
// Randomised scoreboard bench for automata_stage_report_pipe: a batch-level
// reference model queues expected events; a negedge monitor checks them.
module tb_automata_stage_report_pipe;

  localparam int SYMBOL_W    = 8;
  localparam int NUM_REPORTS = 20;
  localparam int REPORT_LAT  = 1;
  localparam int FIFO_DEPTH  = 8;
  localparam int OFFSET_W    = 32;
  localparam int ID_W        = $clog2(NUM_REPORTS);

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   run = 1'b0;
  logic [SYMBOL_W-1:0]    in_symbols = '0;
  logic                   in_reset = 1'b0;
  logic                   report_valid = 1'b0;
  logic [NUM_REPORTS-1:0] report_in = '0;
  logic                   rpt_ready = 1'b0;
  logic                   clr_overflow = 1'b0;
  logic [SYMBOL_W-1:0]    out_symbols;
  logic                   out_reset;
  logic                   out_run;
  logic                   rpt_valid;
  logic [ID_W-1:0]        rpt_id;
  logic [OFFSET_W-1:0]    rpt_offset;
  logic                   overflow;
  logic [15:0]            drop_cnt;

  always #5 clk = ~clk;

  automata_stage_report_pipe #(
    .SYMBOL_W(SYMBOL_W), .NUM_REPORTS(NUM_REPORTS), .REPORT_LAT(REPORT_LAT),
    .FIFO_DEPTH(FIFO_DEPTH), .OFFSET_W(OFFSET_W)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .in_symbols(in_symbols), .in_reset(in_reset),
    .report_valid(report_valid), .report_in(report_in), .out_symbols(out_symbols),
    .out_reset(out_reset), .out_run(out_run), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_id(rpt_id), .rpt_offset(rpt_offset), .overflow(overflow),
    .clr_overflow(clr_overflow), .drop_cnt(drop_cnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                  id;
    logic [OFFSET_W-1:0] off;
  } ev_t;

  ev_t                 exp_ev[$];   // expected serial events, in order
  int                  rem_q[$];    // events still owed by each queued batch
  logic [SYMBOL_W-1:0] m_sym;
  logic                m_rst;
  logic                m_run;
  logic                m_ovf;
  logic [15:0]         m_drop;
  logic [OFFSET_W-1:0] m_off;       // offset the next accepted symbol gets
  logic [OFFSET_W-1:0] m_tag;       // offset of the most recent accepted symbol

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_ev.delete();
    rem_q.delete();
    m_sym  = '0;
    m_rst  = 1'b0;
    m_run  = 1'b0;
    m_ovf  = 1'b0;
    m_drop = 16'd0;
    m_off  = '0;
    m_tag  = '0;
  endtask

  // Effect of the coming clock edge, from the current inputs.
  task automatic model_step();
    bit fire, pop_now, push, accept, drop;
    if (reset) return;
    fire    = (rem_q.size() > 0) && rpt_ready;
    pop_now = fire && (rem_q[0] == 1);
    push    = report_valid && (report_in != '0);
    accept  = push && ((rem_q.size() < FIFO_DEPTH) || pop_now);
    drop    = push && !accept;
    if (fire) begin
      rem_q[0] = rem_q[0] - 1;
      if (rem_q[0] == 0) void'(rem_q.pop_front());
    end
    if (accept) begin
      rem_q.push_back($countones(report_in));
      for (int i = 0; i < NUM_REPORTS; i++)
        if (report_in[i]) exp_ev.push_back('{id: i, off: m_tag});
    end
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr_overflow ? 16'd1 : ((m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1);
    end else if (clr_overflow) begin
      m_ovf  = 1'b0;
      m_drop = 16'd0;
    end
    m_run = run;
    if (run) begin
      m_sym = in_symbols;
      m_rst = in_reset;
      m_tag = m_off;
      m_off = in_reset ? '0 : m_off + 32'd1;
    end
  endtask

  // Caller sets inputs just after a rising edge; this advances one cycle.
  task automatic step();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    rpt_ready = 1'b1; report_valid = 1'b0; run = 1'b0; clr_overflow = 1'b0;
    while (rpt_valid && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 64'(rpt_valid), 64'd0);
  endtask

  function automatic logic [NUM_REPORTS-1:0] rand_vec();
    logic [NUM_REPORTS-1:0] a, b;
    a = NUM_REPORTS'($urandom);
    b = NUM_REPORTS'($urandom);
    return (a & b) | (NUM_REPORTS'(1) << $urandom_range(0, NUM_REPORTS - 1));
  endfunction

  // Scoreboard monitor: outputs settled after the last rising edge.
  always @(negedge clk) begin
    chk("rpt_valid", 64'(rpt_valid), 64'(rem_q.size() != 0));
    if (rpt_valid) begin
      if (exp_ev.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got id %0d off %0d expected none", rpt_id, rpt_offset);
      end else begin
        chk("rpt_id", 64'(rpt_id), 64'(exp_ev[0].id));
        chk("rpt_offset", 64'(rpt_offset), 64'(exp_ev[0].off));
        if (rpt_ready) void'(exp_ev.pop_front());
      end
    end
    chk("out_symbols", 64'(out_symbols), 64'(m_sym));
    chk("out_reset", 64'(out_reset), 64'(m_rst));
    chk("out_run", 64'(out_run), 64'(m_run));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  end

  initial begin
    string abc;
    int    guard;
    abc = "abc";
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_symbols", 64'(out_symbols), 64'd0);
    chk("rst_out_run", 64'(out_run), 64'd0);
    chk("rst_rpt_valid", 64'(rpt_valid), 64'd0);
    chk("rst_rpt_offset", 64'(rpt_offset), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    reset = 1'b0;

    // Symbols a,b,c take offsets 0,1,2; with run low the pipe holds.
    rpt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run = 1'b1; in_symbols = abc[i]; in_reset = 1'b0;
      step();
    end
    chk("sym_c", 64'(out_symbols), 64'h63);
    run = 1'b0; in_symbols = 8'h7A; in_reset = 1'b1;
    repeat (2) step();
    chk("hold_sym", 64'(out_symbols), 64'h63);
    chk("hold_reset", 64'(out_reset), 64'd0);

    // Offsets 3..7, then one report batch 0x5 tagged with offset 7.
    for (int i = 3; i < 8; i++) begin
      run = 1'b1; in_symbols = 8'(i); in_reset = 1'b0;
      step();
    end
    run = 1'b0; report_valid = 1'b1; report_in = 20'h00005;
    step();
    report_valid = 1'b0;
    chk("ev0_id", 64'(rpt_id), 64'd0);
    chk("ev0_off", 64'(rpt_offset), 64'd7);
    step();
    chk("ev1_id", 64'(rpt_id), 64'd2);
    step();
    chk("ev_done", 64'(rpt_valid), 64'd0);

    // Back-pressure: the head must stay put for 5 cycles.
    rpt_ready = 1'b0; report_valid = 1'b1; report_in = 20'h80010;
    step();
    report_valid = 1'b0;
    repeat (5) step();
    drain(20);

    // Nine batches into an eight-entry FIFO with the consumer stalled.
    rpt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run = 1'b1; in_symbols = 8'($urandom); in_reset = 1'b0;
      report_valid = 1'b1; report_in = rand_vec();
      step();
    end
    report_valid = 1'b0; run = 1'b0;
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_cnt", 64'(drop_cnt), 64'd1);
    drain(200);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    chk("ovf_clr", 64'(drop_cnt), 64'd0);

    // Full FIFO whose single-bit head retires as a new batch arrives.
    rpt_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      report_valid = 1'b1; report_in = NUM_REPORTS'(1) << i;
      step();
    end
    rpt_ready = 1'b1; report_valid = 1'b1; report_in = 20'h00300;
    step();
    report_valid = 1'b0;
    chk("swap_no_drop", 64'(drop_cnt), 64'd0);
    drain(100);

    // Restart at offset 100 while reports tagged 97..99 sit in the queue.
    rpt_ready = 1'b0; guard = 0;
    while (m_off != 32'd100 && guard < 300) begin
      run = 1'b1; in_symbols = 8'($urandom); in_reset = 1'b0;
      report_valid = (m_off >= 32'd98); report_in = rand_vec();
      step();
      guard++;
    end
    run = 1'b1; in_reset = 1'b1; report_valid = 1'b1; report_in = rand_vec();
    step();
    in_reset = 1'b0; report_valid = 1'b1; report_in = rand_vec();
    step();
    report_valid = 1'b0; run = 1'b0;
    drain(200);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      run          = ($urandom_range(0, 3) != 0);
      in_symbols   = 8'($urandom);
      in_reset     = ($urandom_range(0, 31) == 0);
      report_valid = ($urandom_range(0, 2) == 0);
      report_in    = ($urandom_range(0, 4) == 0) ? '0 : rand_vec();
      rpt_ready    = ($urandom_range(0, 2) != 0);
      clr_overflow = ($urandom_range(0, 40) == 0);
      step();
    end
    drain(400);

    // Asynchronous reset in the middle of a drain.
    rpt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      report_valid = 1'b1; report_in = rand_vec();
      step();
    end
    report_valid = 1'b0; rpt_ready = 1'b1;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(rpt_valid), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) step();
    chk("leftover_events", 64'(exp_ev.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
